vec_alu_pipe: RTL and testbench

VEC_ALU_PIPE -- requirements
Module: vec_alu_pipe

---
 rtl/vec_alu_pipe.sv | 168 ++++++++++++++++
 tb/tb_vec_alu_pipe.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/vec_alu_pipe.sv
// vec_alu_pipe: two-stage SIMD ALU over 8/16/32/64-bit lanes; define VEC_ALU_SAT_EN to add SADDS/SSUBS.
// Latency 2 cycles, 1 beat/cycle; in_ready = !s1_valid || !s2_valid || out_ready, outputs held while stalled.
module vec_alu_pipe #(
  parameter int BITS           = 64,
  parameter int PRECISION_BITS = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [BITS-1:0]           a,
  input  logic [BITS-1:0]           b,
  input  logic [3:0]                opcode,
  input  logic [PRECISION_BITS-1:0] precision,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [BITS-1:0]           result_final,
  output logic [BITS/8-1:0]         lane_carry,
  output logic                      op_err
);
  localparam int NP = 1 << PRECISION_BITS;
  localparam int CW = BITS / 8;

  localparam logic [3:0] OP_AND    = 4'b0000;
  localparam logic [3:0] OP_OR     = 4'b0001;
  localparam logic [3:0] OP_XOR    = 4'b0010;
  localparam logic [3:0] OP_ADD    = 4'b0011;
  localparam logic [3:0] OP_SEQ    = 4'b0100;
  localparam logic [3:0] OP_SNE    = 4'b0101;
  localparam logic [3:0] OP_SUB    = 4'b0110;
  localparam logic [3:0] OP_AVGSUB = 4'b0111;
  localparam logic [3:0] OP_AVGADD = 4'b1000;
  localparam logic [3:0] OP_MAX    = 4'b1001;
  localparam logic [3:0] OP_MIN    = 4'b1010;
`ifdef VEC_ALU_SAT_EN
  localparam logic [3:0] OP_SADDS  = 4'b1011;
  localparam logic [3:0] OP_SSUBS  = 4'b1100;
`endif

  typedef struct packed {
    logic [BITS-1:0]           a;
    logic [BITS-1:0]           b;
    logic [3:0]                op;
    logic [PRECISION_BITS-1:0] prec;
  } beat_t;

  beat_t s1;
  logic  s1_valid;
  logic  s2_valid;
  logic  en1;
  logic  en2;
  logic  s1_ok;

  assign en2       = !s2_valid || out_ready;
  assign en1       = !s1_valid || en2;
  assign in_ready  = en1;
  assign out_valid = s2_valid;

  // One result per lane width is computed in parallel; the beat's precision picks one.
  logic [NP-1:0][BITS-1:0] res_p;
  logic [NP-1:0][CW-1:0]   cy_p;

  for (genvar p = 0; p < NP; p++) begin : g_prec
    localparam int W = 8 << p;
    if (W <= BITS) begin : g_lane
      localparam int NL = BITS / W;
      localparam int CL = W / 8;
      logic [BITS-1:0] res;
      logic [CW-1:0]   cy;

      for (genvar l = 0; l < NL; l++) begin : g_l
`ifdef VEC_ALU_SAT_EN
        localparam logic [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};
        localparam logic [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};
`endif
        logic [W-1:0] la;
        logic [W-1:0] lb;
        logic [W-1:0] r;
        logic [W:0]   sum;
        logic [W:0]   dif;
        logic         lt;
        logic         c;

        assign la  = s1.a[l*W +: W];
        assign lb  = s1.b[l*W +: W];
        assign sum = {1'b0, la} + {1'b0, lb};
        assign dif = {1'b0, la} - {1'b0, lb};
        assign lt  = $signed(la) < $signed(lb);

        // The extra sum/difference bit is the carry/borrow and also feeds the averaging ops.
        always_comb begin
          r = '0;
          c = 1'b0;
          case (s1.op)
            OP_AND:    r = la & lb;
            OP_OR:     r = la | lb;
            OP_XOR:    r = la ^ lb;
            OP_ADD:    begin r = sum[W-1:0]; c = sum[W]; end
            OP_SEQ:    r = {{(W-1){1'b0}}, la == lb};
            OP_SNE:    r = {{(W-1){1'b0}}, la != lb};
            OP_SUB:    begin r = dif[W-1:0]; c = dif[W]; end
            OP_AVGSUB: r = dif[W:1];
            OP_AVGADD: r = sum[W:1];
            OP_MAX:    r = lt ? lb : la;
            OP_MIN:    r = lt ? la : lb;
`ifdef VEC_ALU_SAT_EN
            OP_SADDS: begin
              r = sum[W-1:0];
              if (la[W-1] == lb[W-1] && sum[W-1] != la[W-1]) begin
                r = la[W-1] ? SMIN : SMAX;
                c = 1'b1;
              end
            end
            OP_SSUBS: begin
              r = dif[W-1:0];
              if (la[W-1] != lb[W-1] && dif[W-1] != la[W-1]) begin
                r = la[W-1] ? SMIN : SMAX;
                c = 1'b1;
              end
            end
`endif
            default: ;
          endcase
        end

        assign res[l*W +: W] = r;
        assign cy[l*CL +: CL] = CL'(c) << (CL - 1);
      end

      assign res_p[p] = res;
      assign cy_p[p]  = cy;
    end else begin : g_none
      assign res_p[p] = '0;
      assign cy_p[p]  = '0;
    end
  end

  always_comb begin
    s1_ok = (s1.op <= OP_MIN);
`ifdef VEC_ALU_SAT_EN
    if (s1.op == OP_SADDS || s1.op == OP_SSUBS) s1_ok = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid     <= 1'b0;
      s2_valid     <= 1'b0;
      s1           <= '0;
      result_final <= '0;
      lane_carry   <= '0;
      op_err       <= 1'b0;
    end else begin
      if (en1) begin
        s1_valid <= in_valid;
        if (in_valid) s1 <= '{a: a, b: b, op: opcode, prec: precision};
      end
      if (en2) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          result_final <= s1_ok ? res_p[s1.prec] : '0;
          lane_carry   <= s1_ok ? cy_p[s1.prec] : '0;
          op_err       <= !s1_ok;
        end
      end
    end
  end
endmodule

// File: tb/tb_vec_alu_pipe.sv
// Bench for vec_alu_pipe: directed cases plus random traffic against a lane-arithmetic reference model.
module tb_vec_alu_pipe;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] a;
  logic [63:0] b;
  logic [3:0]  opcode;
  logic [1:0]  precision;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result_final;
  logic [7:0]  lane_carry;
  logic        op_err;

  vec_alu_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .opcode(opcode), .precision(precision),
    .out_valid(out_valid), .out_ready(out_ready),
    .result_final(result_final), .lane_carry(lane_carry), .op_err(op_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] r;
    logic [7:0]  c;
    logic        e;
    int          acc;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  logic last_acc = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Lane arithmetic done on sign-extended / zero-extended integers, lane by lane.
  function automatic exp_t model(input logic [3:0] op, input logic [1:0] pr,
                                 input logic [63:0] x, input logic [63:0] y);
    exp_t e;
    int w;
    logic [63:0] mask;
    logic [63:0] lane;
    logic [64:0] ux, uy, u;
    logic signed [65:0] sx, sy, t, hi, lo;
    logic carry;
    logic sat_ok;
    w = 8 << pr;
    mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    e.r = '0;
    e.c = '0;
    e.acc = cyc;
    sat_ok = 1'b0;
`ifdef VEC_ALU_SAT_EN
    sat_ok = 1'b1;
`endif
    e.e = !(op <= 4'd10 || (sat_ok && (op == 4'd11 || op == 4'd12)));
    if (e.e) return e;
    hi = (66'sd1 <<< (w - 1)) - 66'sd1;
    lo = -(66'sd1 <<< (w - 1));
    for (int k = 0; k < 64 / w; k++) begin
      ux = {1'b0, (x >> (k * w)) & mask};
      uy = {1'b0, (y >> (k * w)) & mask};
      sx = $signed({1'b0, ux});
      sy = $signed({1'b0, uy});
      if (ux[w-1]) sx = sx - (66'sd1 <<< w);
      if (uy[w-1]) sy = sy - (66'sd1 <<< w);
      carry = 1'b0;
      lane = '0;
      case (op)
        4'd0: begin u = ux & uy; lane = u[63:0]; end
        4'd1: begin u = ux | uy; lane = u[63:0]; end
        4'd2: begin u = ux ^ uy; lane = u[63:0]; end
        4'd3: begin u = ux + uy; lane = u[63:0]; carry = u[w]; end
        4'd4: lane = {63'd0, ux == uy};
        4'd5: lane = {63'd0, ux != uy};
        4'd6: begin u = ux - uy; lane = u[63:0]; carry = (ux < uy); end
        4'd7: begin u = ((ux - uy) & ((65'd1 << (w + 1)) - 65'd1)) >> 1; lane = u[63:0]; end
        4'd8: begin u = (ux + uy) >> 1; lane = u[63:0]; end
        4'd9: begin u = (sx > sy) ? ux : uy; lane = u[63:0]; end
        4'd10: begin u = (sx < sy) ? ux : uy; lane = u[63:0]; end
        4'd11, 4'd12: begin
          t = (op == 4'd11) ? sx + sy : sx - sy;
          if (t > hi) begin t = hi; carry = 1'b1; end
          else if (t < lo) begin t = lo; carry = 1'b1; end
          lane = t[63:0];
        end
        default: lane = '0;
      endcase
      e.r = e.r | ((lane & mask) << (k * w));
      e.c[(k + 1) * (w / 8) - 1] = carry;
    end
    return e;
  endfunction

  // One clock: drive at the falling edge, check just after, let the rising edge happen.
  task automatic step(input logic v, input logic [3:0] op, input logic [1:0] pr,
                      input logic [63:0] av, input logic [63:0] bv, input logic ordy, input logic r);
    exp_t e;
    logic exp_ov;
    in_valid = v; opcode = op; precision = pr; a = av; b = bv; out_ready = ordy; rst = r;
    last_acc = 1'b0;
    #1;
    if (!r) begin
      check("in_ready", 64'(in_ready), 64'(q.size() < 2 || ordy));
      exp_ov = (q.size() > 0) && (cyc - q[0].acc >= 2);
      check("out_valid", 64'(out_valid), 64'(exp_ov));
      if (out_valid && q.size() > 0) begin
        check("result_final", result_final, q[0].r);
        check("lane_carry", 64'(lane_carry), 64'(q[0].c));
        check("op_err", 64'(op_err), 64'(q[0].e));
        if (ordy) void'(q.pop_front());
      end
      if (v && in_ready) begin
        e = model(op, pr, av, bv);
        q.push_back(e);
        last_acc = 1'b1;
      end
    end
    @(posedge clk);
    cyc++;
    if (r) q.delete();
    @(negedge clk);
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 4'd0, 2'd0, 64'd0, 64'd0, ordy, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q.size() > 0; i++) idle(1'b1);
    check("drain_empty", 64'(q.size()), 64'd0);
  endtask

  task automatic directed(input string tag, input logic [3:0] op, input logic [1:0] pr,
                          input logic [63:0] av, input logic [63:0] bv,
                          input logic [63:0] er, input logic [7:0] ec, input logic ee);
    step(1'b1, op, pr, av, bv, 1'b1, 1'b0);
    idle(1'b1);
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_res"}, result_final, er);
    check({tag, "_carry"}, 64'(lane_carry), 64'(ec));
    check({tag, "_err"}, 64'(op_err), 64'(ee));
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int sent;
    logic [63:0] sa [4];
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; opcode = '0; precision = '0; out_ready = 1'b0;
    @(negedge clk);
    step(1'b0, 4'd0, 2'd0, 64'd0, 64'd0, 1'b0, 1'b1);
    step(1'b0, 4'd0, 2'd0, 64'd0, 64'd0, 1'b0, 1'b1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", result_final, 64'd0);
    check("rst_carry", 64'(lane_carry), 64'd0);
    check("rst_err", 64'(op_err), 64'd0);
    rst = 1'b0;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);

    directed("add8", 4'h3, 2'd0, 64'h01FF_0000_0000_0010, 64'h0101_0000_0000_0005,
             64'h0200_0000_0000_0015, 8'h40, 1'b0);
    directed("avgadd64", 4'h8, 2'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
             64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 1'b0);
    directed("min16", 4'hA, 2'd1, 64'h8000_0001_7FFF_0005, 64'h0001_0000_8000_0006,
             64'h8000_0000_8000_0005, 8'h00, 1'b0);
    directed("avgsub8", 4'h7, 2'd0, 64'h01, 64'h03, 64'hFF, 8'h00, 1'b0);
    directed("avgadd8", 4'h8, 2'd0, 64'hFF, 64'h01, 64'h80, 8'h00, 1'b0);
    directed("sub32", 4'h6, 2'd2, 64'h1, 64'h2, 64'h0000_0000_FFFF_FFFF, 8'h08, 1'b0);
    directed("seq16", 4'h4, 2'd1, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0,
             64'h0001_0001_0001_0001, 8'h00, 1'b0);
    directed("badop", 4'hF, 2'd0, 64'h1234, 64'h5678, 64'd0, 8'h00, 1'b1);
`ifdef VEC_ALU_SAT_EN
    directed("sadds8", 4'hB, 2'd0, 64'h7F, 64'h01, 64'h7F, 8'h01, 1'b0);
`else
    directed("sadds8", 4'hB, 2'd0, 64'h7F, 64'h01, 64'd0, 8'h00, 1'b1);
`endif

    // Four beats into a stalled output: only two fit, then all four drain in order.
    for (int i = 0; i < 4; i++) sa[i] = {$urandom, $urandom};
    sent = 0;
    for (int t = 0; t < 40 && sent < 4; t++) begin
      step(1'b1, 4'h3, 2'(t % 4), sa[sent], ~sa[sent], (t >= 6), 1'b0);
      if (last_acc) sent++;
      if (t == 5) check("stall_accepted", 64'(sent), 64'd2);
    end
    check("stall_all_sent", 64'(sent), 64'd4);
    drain();

    // Reset with two beats in flight: neither may ever come out.
    step(1'b1, 4'h1, 2'd0, 64'hAAAA, 64'h5555, 1'b0, 1'b0);
    step(1'b1, 4'h2, 2'd1, 64'hF0F0, 64'h0FF0, 1'b0, 1'b0);
    step(1'b0, 4'd0, 2'd0, 64'd0, 64'd0, 1'b0, 1'b1);
    check("rst_mid_out_valid", 64'(out_valid), 64'd0);
    for (int i = 0; i < 6; i++) idle(1'b1);

    // Random traffic with random backpressure and mode changes every beat.
    for (int i = 0; i < 400; i++) begin
      logic [63:0] ra;
      logic [63:0] rb;
      ra = {$urandom, $urandom};
      rb = ($urandom_range(0, 3) == 0) ? ra : {$urandom, $urandom};
      step(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
           ra, rb, ($urandom_range(0, 3) != 0), 1'b0);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
